// File: rtl/mips_ctrl_alu.sv
// Decode-and-execute slice: main control, ALU control and a 32-bit ALU.
// The ALU result and zero flag are registered to form the EX/MEM boundary.
module mips_ctrl_alu #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    input  logic [W-1:0] seimm,
    output logic         regdst,
    output logic         branch_eq,
    output logic         branch_ne,
    output logic         memread,
    output logic         memwrite,
    output logic         memtoreg,
    output logic         alusrc,
    output logic         regwrite,
    output logic         jump,
    output logic [1:0]   aluop,
    output logic [5:0]   aluctl,
    output logic [W-1:0] alu_out,
    output logic         zero,
    output logic [W-1:0] alu_out_q,
    output logic         zero_q
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] CTL_AND = 6'd0;
    localparam logic [5:0] CTL_OR  = 6'd1;
    localparam logic [5:0] CTL_ADD = 6'd2;
    localparam logic [5:0] CTL_SUB = 6'd6;
    localparam logic [5:0] CTL_SLT = 6'd7;
    localparam logic [5:0] CTL_NOR = 6'd12;
    localparam logic [5:0] CTL_XOR = 6'd13;

    logic [W-1:0] w_b;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        regdst    = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        memtoreg  = 1'b0;
        alusrc    = 1'b0;
        regwrite  = 1'b0;
        jump      = 1'b0;
        aluop     = 2'b00;
        unique case (opcode)
            OP_RTYPE: begin regdst = 1'b1; regwrite = 1'b1; aluop = 2'b10; end
            OP_LW:    begin memread = 1'b1; memtoreg = 1'b1; alusrc = 1'b1; regwrite = 1'b1; end
            OP_SW:    begin memwrite = 1'b1; alusrc = 1'b1; end
            OP_BEQ:   begin branch_eq = 1'b1; aluop = 2'b01; end
            OP_BNE:   begin branch_ne = 1'b1; aluop = 2'b01; end
            OP_ADDI:  begin alusrc = 1'b1; regwrite = 1'b1; end
            OP_J:     jump = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        aluctl = CTL_ADD;
        case (aluop)
            2'b01: aluctl = CTL_SUB;
            2'b10: begin
                case (funct)
                    6'b100010: aluctl = CTL_SUB;
                    6'b100100: aluctl = CTL_AND;
                    6'b100101: aluctl = CTL_OR;
                    6'b100110: aluctl = CTL_XOR;
                    6'b100111: aluctl = CTL_NOR;
                    6'b101010: aluctl = CTL_SLT;
                    default:   aluctl = CTL_ADD;
                endcase
            end
            default: aluctl = CTL_ADD;
        endcase
    end

    assign w_b = alusrc ? seimm : rt_data;

    always_comb begin
        alu_out = '0;
        case (aluctl)
            CTL_AND: alu_out = rs_data & w_b;
            CTL_OR:  alu_out = rs_data | w_b;
            CTL_ADD: alu_out = rs_data + w_b;
            CTL_SUB: alu_out = rs_data - w_b;
            CTL_SLT: alu_out = {{(W-1){1'b0}}, ($signed(rs_data) < $signed(w_b))};
            CTL_NOR: alu_out = ~(rs_data | w_b);
            CTL_XOR: alu_out = rs_data ^ w_b;
            default: alu_out = '0;
        endcase
    end

    assign zero = (alu_out == '0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else if (flush) begin
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            alu_out_q <= alu_out;
            zero_q    <= zero;
        end
    end

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// Directed self-checking bench for mips_ctrl_alu: decode, ALU results,
// registered outputs, asynchronous reset and flush.
module tb_mips_ctrl_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] seimm;
    logic        regdst, branch_eq, branch_ne, memread, memwrite;
    logic        memtoreg, alusrc, regwrite, jump;
    logic [1:0]  aluop;
    logic [5:0]  aluctl;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] alu_out_q;
    logic        zero_q;

    int total = 0;
    int bad   = 0;

    mips_ctrl_alu #(.W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .opcode(opcode), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .seimm(seimm),
        .regdst(regdst), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .alusrc(alusrc), .regwrite(regwrite), .jump(jump),
        .aluop(aluop), .aluctl(aluctl),
        .alu_out(alu_out), .zero(zero),
        .alu_out_q(alu_out_q), .zero_q(zero_q)
    );

    always #5 clk = ~clk;

    // Control word order: regdst branch_eq branch_ne memread memwrite memtoreg alusrc regwrite jump
    function automatic logic [31:0] ctrl_word();
        return {23'd0, regdst, branch_eq, branch_ne, memread, memwrite,
                memtoreg, alusrc, regwrite, jump};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        opcode  = op;
        funct   = fn;
        rs_data = a;
        rt_data = b;
        seimm   = imm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        check("reset_q", alu_out_q, 32'd0);
        check("reset_zq", {31'd0, zero_q}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // R-type add
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        check("radd_ctrl", ctrl_word(), 32'b100000010);
        check("radd_aluop", {30'd0, aluop}, 32'd2);
        check("radd_aluctl", {26'd0, aluctl}, 32'd2);
        check("radd_out", alu_out, 32'd12);
        check("radd_zero", {31'd0, zero}, 32'd0);
        tick();
        check("radd_q", alu_out_q, 32'd12);
        check("radd_zq", {31'd0, zero_q}, 32'd0);

        // Wrap and signed compare
        drive(6'b000000, 6'b100010, 32'd0, 32'd1, 32'd0);
        check("sub_wrap", alu_out, 32'hFFFF_FFFF);
        check("sub_aluctl", {26'd0, aluctl}, 32'd6);
        drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("slt_neg", alu_out, 32'd1);
        check("slt_aluctl", {26'd0, aluctl}, 32'd7);
        drive(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0);
        check("slt_pos", alu_out, 32'd0);
        check("slt_pos_zero", {31'd0, zero}, 32'd1);

        // lw uses the immediate, ignores rt
        drive(6'b100011, 6'b000000, 32'd100, 32'd999, 32'hFFFF_FFFC);
        check("lw_ctrl", ctrl_word(), 32'b000101110);
        check("lw_aluop", {30'd0, aluop}, 32'd0);
        check("lw_out", alu_out, 32'd96);

        drive(6'b101011, 6'b100010, 32'd8, 32'd999, 32'd4);
        check("sw_ctrl", ctrl_word(), 32'b000010100);
        check("sw_out", alu_out, 32'd12);

        // beq equal operands
        drive(6'b000100, 6'b000000, 32'd42, 32'd42, 32'd0);
        check("beq_ctrl", ctrl_word(), 32'b010000000);
        check("beq_aluop", {30'd0, aluop}, 32'd1);
        check("beq_aluctl", {26'd0, aluctl}, 32'd6);
        check("beq_out", alu_out, 32'd0);
        check("beq_zero", {31'd0, zero}, 32'd1);
        tick();
        check("beq_zq", {31'd0, zero_q}, 32'd1);
        check("beq_q", alu_out_q, 32'd0);

        drive(6'b000101, 6'b000000, 32'd42, 32'd40, 32'd0);
        check("bne_ctrl", ctrl_word(), 32'b001000000);
        check("bne_out", alu_out, 32'd2);
        check("bne_zero", {31'd0, zero}, 32'd0);

        drive(6'b001000, 6'b100010, 32'd10, 32'd999, 32'd5);
        check("addi_ctrl", ctrl_word(), 32'b000000110);
        check("addi_out", alu_out, 32'd15);

        drive(6'b000010, 6'b000000, 32'd3, 32'd4, 32'd0);
        check("j_ctrl", ctrl_word(), 32'b000000001);
        check("j_aluop", {30'd0, aluop}, 32'd0);

        // Logic ops and unknown codes
        drive(6'b000000, 6'b100100, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0);
        check("and_out", alu_out, 32'h00F0_0000);
        check("and_aluctl", {26'd0, aluctl}, 32'd0);
        drive(6'b000000, 6'b100101, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0);
        check("or_out", alu_out, 32'hFFF0_0000);
        check("or_aluctl", {26'd0, aluctl}, 32'd1);
        drive(6'b000000, 6'b100110, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0);
        check("xor_out", alu_out, 32'hFF00_0000);
        check("xor_aluctl", {26'd0, aluctl}, 32'd13);
        drive(6'b000000, 6'b100111, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0);
        check("nor_out", alu_out, 32'h000F_FFFF);
        check("nor_aluctl", {26'd0, aluctl}, 32'd12);
        drive(6'b000000, 6'b111111, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0);
        check("unk_funct_aluctl", {26'd0, aluctl}, 32'd2);
        check("unk_funct_out", alu_out, 32'h00E0_0000);
        drive(6'b111111, 6'b100010, 32'hF0F0_0000, 32'h0FF0_0000, 32'hFFFF_FFFF);
        check("unk_op_ctrl", ctrl_word(), 32'd0);
        check("unk_op_aluop", {30'd0, aluop}, 32'd0);
        check("unk_op_out", alu_out, 32'h00E0_0000);

        // Asynchronous reset between edges, then release
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        tick();
        check("pre_reset_q", alu_out_q, 32'd12);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_q", alu_out_q, 32'd0);
        tick();
        check("held_reset_q", alu_out_q, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("release_q", alu_out_q, 32'd12);

        // Flush overrides capture
        drive(6'b000100, 6'b000000, 32'd42, 32'd42, 32'd0);
        flush = 1'b1;
        tick();
        check("flush_q", alu_out_q, 32'd0);
        check("flush_zq", {31'd0, zero_q}, 32'd0);
        flush = 1'b0;
        tick();
        check("post_flush_zq", {31'd0, zero_q}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_alu.md
Name: mips_ctrl_alu

Overview:
Combined decode-and-execute slice for the five-stage MIPS pipeline.
- Main control decodes the 6-bit opcode into pipeline control signals.
- ALU control maps aluop and funct to a 6-bit ALU operation code.
- A 32-bit ALU executes the operation on the register and immediate operands.
- The ALU result and zero flag are also registered, forming the EX to MEM boundary for those two values.

Parameters:
- W, 32, datapath width in bits. Only 32 is required to be supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of the registered outputs
- opcode  in  6  instruction bits [31:26]
- funct  in  6  instruction bits [5:0]
- rs_data  in  32  ALU operand A
- rt_data  in  32  register operand B
- seimm  in  32  sign-extended immediate
- regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, alusrc, regwrite, jump  out  1 each  decoded control signals (combinational)
- aluop  out  2  decoded ALU class (combinational)
- aluctl  out  6  ALU operation code (combinational)
- alu_out  out  32  combinational ALU result
- zero  out  1  combinational flag, alu_out == 0
- alu_out_q  out  32  registered ALU result
- zero_q  out  1  registered zero flag

Behaviour:
- Main decode (combinational). Every signal not listed for an opcode is 0.
  - 000000 R-type: regdst=1, regwrite=1, aluop=10.
  - 100011 lw: memread=1, memtoreg=1, alusrc=1, regwrite=1, aluop=00.
  - 101011 sw: memwrite=1, alusrc=1, aluop=00.
  - 000100 beq: branch_eq=1, aluop=01.
  - 000101 bne: branch_ne=1, aluop=01.
  - 001000 addi: alusrc=1, regwrite=1, aluop=00.
  - 000010 j: jump=1.
  - Any other opcode: all control outputs 0, aluop=00 (bubble/nop).
- ALU control (combinational):
  - aluop 00 selects ADD.
  - aluop 01 selects SUB.
  - aluop 11 selects ADD.
  - aluop 10 decodes funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT. Any other funct selects ADD.
- aluctl encodings: AND=6'd0, OR=6'd1, ADD=6'd2, SUB=6'd6, SLT=6'd7, NOR=6'd12, XOR=6'd13.
- Operand B: B = alusrc ? seimm : rt_data.
- ALU arithmetic:
  - ADD and SUB are modulo 2^32; there is no overflow flag or trap.
  - SLT is a signed two's-complement compare: 32'd1 if A < B, otherwise 32'd0.
  - NOR is ~(A|B).
  - Any aluctl value outside the defined set produces alu_out = 0.
- zero = (alu_out == 32'd0).
- Registered outputs:
  - reset low (asynchronous): alu_out_q = 0 and zero_q = 0 immediately, held until reset goes high.
  - On rising clk with reset high: if flush=1, alu_out_q = 0 and zero_q = 0. Otherwise alu_out_q = alu_out and zero_q = zero.
  - Latency is one cycle from inputs to the _q outputs. All other outputs have zero latency.
- Reset deasserting in the same cycle as a clock edge: the first capture occurs on the next edge on which reset is sampled high.
- Reset values: combinational outputs have no reset value; they always reflect the current inputs. Registered outputs reset to 0.
- No internal state exists besides alu_out_q and zero_q.

Test Plan:
- R-type add: opcode=000000, funct=100000, rs=5, rt=7.
  - Decode: regdst=1, regwrite=1, aluop=10, aluctl=2.
  - Result: alu_out=12, zero=0; alu_out_q=12 after one edge.
- Wrap and signed compare (aluop=10):
  - funct=100010 (SUB), rs=0, rt=1: alu_out=32'hFFFFFFFF.
  - funct=101010 (SLT), rs=32'hFFFFFFFF, rt=1: alu_out=1 (signed -1 < 1).
  - funct=101010 (SLT), rs=1, rt=32'hFFFFFFFF: alu_out=0.
- lw with alusrc: opcode=100011, rs=100, rt=999, seimm=32'hFFFFFFFC.
  - Decode: memread=1, memtoreg=1, alusrc=1, regwrite=1.
  - Result: alu_out=96 (immediate used, rt_data ignored).
- beq equal operands: opcode=000100, rs=rt=42.
  - Decode: branch_eq=1, aluctl=6.
  - Result: alu_out=0, zero=1; zero_q=1 after one edge.
- Logic ops and unknown codes, rs=32'hF0F0_0000, rt=32'h0FF0_0000:
  - funct AND gives 32'h00F0_0000; OR gives 32'hFFF0_0000; XOR gives 32'hFF00_0000; NOR gives 32'h000F_FFFF.
  - Unknown funct behaves as ADD.
  - Unknown opcode 111111 drives all control outputs to 0.
- Reset and flush:
  - With alu_out_q=12, drive reset low between edges: alu_out_q=0 immediately.
  - After release, alu_out_q captures on the next edge.
  - flush=1 on an edge gives alu_out_q=0, zero_q=0 regardless of operands.
